// File: rtl/timer_bcd_countdown_pkg.sv
// Shared constants and helpers for the BCD mm:ss countdown timer.
package timer_bcd_countdown_pkg;

   localparam int         DIGIT_W      = 4;
   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   // Limit a loaded digit to its legal maximum.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

endpackage

// File: rtl/timer_bcd_countdown_digit.sv
// One BCD down/up digit with borrow and carry chaining.
module timer_bcd_countdown_digit
   import timer_bcd_countdown_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] ld_val,
   input  logic       dec,
   input  logic       inc,
   input  logic       borrow_in,
   input  logic       carry_in,
   output logic [3:0] q,
   output logic       borrow_out,
   output logic       carry_out,
   output logic       is_zero
);

   logic dec_en, inc_en;

   // A digit only moves when its lower neighbour rolls over.
   assign dec_en     = dec & borrow_in;
   assign inc_en     = inc & carry_in;
   assign borrow_out = dec_en & (q == 4'd0);
   assign carry_out  = inc_en & (q == MAX);
   assign is_zero    = (q == 4'd0);

   // Digit register: clear > load > decrement > increment.
   always_ff @(posedge clk) begin
      if (clear)       q <= 4'd0;
      else if (load)   q <= ld_val;
      else if (dec_en) q <= (q == 4'd0) ? MAX : q - 4'd1;
      else if (inc_en) q <= (q == MAX) ? 4'd0 : q + 4'd1;
   end

endmodule

// File: rtl/timer_bcd_countdown.sv
// Parametrised BCD mm:ss countdown timer with load, +1 minute and expiry pulse.
module timer_bcd_countdown
   import timer_bcd_countdown_pkg::*;
#(
   parameter int MIN_DIGITS = 2,
   parameter int TICK_DIV   = 1
) (
   input  logic                        clk,
   input  logic                        clear,
   input  logic                        enable,
   input  logic                        load,
   input  logic                        add_min,
   input  logic [4*(MIN_DIGITS+2)-1:0] data,
   output logic [3:0]                  so,
   output logic [3:0]                  st,
   output logic [4*MIN_DIGITS-1:0]     min,
   output logic                        zero,
   output logic                        done,
   output logic                        running
);

   localparam int ND = MIN_DIGITS + 2;                 // digit 0 = so, 1 = st, 2.. = minutes
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [ND-1:0][3:0]     q;
   logic [ND-1:0][3:0]     ldv;
   logic [ND-1:0]          bo, co, iz;
   logic [MIN_DIGITS-1:0]  min_nine;
   logic [PW-1:0]          presc;
   logic                   sat, tick, dec, inc, dig_load, done_nxt;
   logic                   unused_ok;

   assign zero     = &iz;
   assign running  = enable & ~zero;
   assign tick     = enable & ~zero & (presc == PLAST);
   assign sat      = &min_nine;
   // +1 minute on an all-nines minute field saturates the whole display.
   assign dig_load = load | (add_min & sat);
   assign dec      = tick & ~load & ~add_min;
   assign inc      = add_min & ~load & ~sat;
   assign done_nxt = dec & (&iz[ND-1:1]) & (q[0] == 4'd1);

   assign so = q[0];
   assign st = q[1];

   genvar i;
   generate
      for (i = 0; i < ND; i++) begin : g_dig
         localparam logic [3:0] DMAX = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
         logic inc_d, cin_d, bin_d;

         assign ldv[i] = load ? clamp_digit(data[4*i +: 4], DMAX) : DMAX;
         assign bin_d  = (i == 0) ? 1'b1 : bo[(i == 0) ? 0 : i-1];
         assign inc_d  = (i >= 2) ? inc : 1'b0;
         assign cin_d  = (i <= 2) ? 1'b1 : co[(i == 0) ? 0 : i-1];

         timer_bcd_countdown_digit #(.MAX(DMAX)) u_dig (
            .clk       (clk),
            .clear     (clear),
            .load      (dig_load),
            .ld_val    (ldv[i]),
            .dec       (dec),
            .inc       (inc_d),
            .borrow_in (bin_d),
            .carry_in  (cin_d),
            .q         (q[i]),
            .borrow_out(bo[i]),
            .carry_out (co[i]),
            .is_zero   (iz[i])
         );

         if (i >= 2) begin : g_min
            assign min[4*(i-2) +: 4] = q[i];
            assign min_nine[i-2]     = (q[i] == BCD_MAX);
         end
      end
   endgenerate

   // Borrow out of the top digit and carries out of the seconds digits never feed anything.
   assign unused_ok = &{bo[ND-1], co[1:0], co[ND-1]};

   // Prescaler: advances on enabled non-zero clocks, parked at 0 while the count is zero.
   always_ff @(posedge clk) begin
      if (clear || load)  presc <= '0;
      else if (zero)      presc <= '0;
      else if (enable)    presc <= (presc == PLAST) ? '0 : presc + PW'(1);
   end

   // Expiry pulse: set only when a decrement takes 00:01 to 00:00.
   always_ff @(posedge clk) begin
      if (clear || load) done <= 1'b0;
      else               done <= done_nxt;
   end

endmodule

// File: tb/tb_timer_bcd_countdown.sv
// Self-checking bench: TICK_DIV=1 and TICK_DIV=4 instances vs. a seconds-count model.
module tb_timer_bcd_countdown;

   logic        clk = 1'b0;
   logic        clear, enable, load, add_min;
   logic [15:0] data;

   logic [3:0] so1, st1, so4, st4;
   logic [7:0] min1, min4;
   logic       zero1, done1, run1, zero4, done4, run4;

   int mt[2];      // remaining time in seconds
   int mp[2];      // enabled-clock phase within one second
   int md[2];      // expected done pulse
   int tdiv[2] = '{1, 4};
   int nchk = 0, nerr = 0;
   string tag = "reset";

   always #5 clk = ~clk;

   timer_bcd_countdown #(.MIN_DIGITS(2), .TICK_DIV(1)) d1 (
      .clk(clk), .clear(clear), .enable(enable), .load(load), .add_min(add_min), .data(data),
      .so(so1), .st(st1), .min(min1), .zero(zero1), .done(done1), .running(run1));

   timer_bcd_countdown #(.MIN_DIGITS(2), .TICK_DIV(4)) d4 (
      .clk(clk), .clear(clear), .enable(enable), .load(load), .add_min(add_min), .data(data),
      .so(so4), .st(st4), .min(min4), .zero(zero4), .done(done4), .running(run4));

   function automatic int clampv(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int ld_total(input logic [15:0] d);
      int so_v, st_v, m0, m1;
      so_v = clampv(int'(d[3:0]), 9);
      st_v = clampv(int'(d[7:4]), 5);
      m0   = clampv(int'(d[11:8]), 9);
      m1   = clampv(int'(d[15:12]), 9);
      return (m1 * 10 + m0) * 60 + st_v * 10 + so_v;
   endfunction

   task automatic model_edge(input int k);
      bit t;
      t = enable && (mt[k] != 0) && (mp[k] == tdiv[k] - 1);
      if (clear) begin
         mt[k] = 0; mp[k] = 0; md[k] = 0;
      end else if (load) begin
         mt[k] = ld_total(data); mp[k] = 0; md[k] = 0;
      end else begin
         if (mt[k] == 0) mp[k] = 0;
         else if (enable) mp[k] = (mp[k] + 1) % tdiv[k];
         md[k] = 0;
         if (add_min) begin
            if (mt[k] / 60 == 99) mt[k] = 99 * 60 + 59;
            else                  mt[k] = mt[k] + 60;
         end else if (t) begin
            mt[k] = mt[k] - 1;
            md[k] = (mt[k] == 0);
         end
      end
   endtask

   function automatic logic [18:0] expv(input int k);
      int m, s;
      logic z;
      m = mt[k] / 60;
      s = mt[k] % 60;
      z = (mt[k] == 0);
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), z, md[k] != 0, enable & ~z};
   endfunction

   task automatic check(input int k);
      logic [18:0] obs, exp;
      obs = (k == 0) ? {min1, st1, so1, zero1, done1, run1} : {min4, st4, so4, zero4, done4, run4};
      exp = expv(k);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s div=%0d observed=%h expected=%h", tag, tdiv[k], obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check(0);
      check(1);
   endtask

   task automatic do_load(input logic [15:0] d);
      data = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic do_add();
      add_min = 1'b1;
      step();
      add_min = 1'b0;
   endtask

   initial begin
      clear = 1'b1; enable = 1'b0; load = 1'b0; add_min = 1'b0; data = '0;
      mt = '{0, 0}; mp = '{0, 0}; md = '{0, 0};
      step();
      clear = 1'b0;

      tag = "run_0105"; enable = 1'b1;
      do_load(16'h0105);
      repeat (67) step();

      tag = "pause_0003";
      do_load(16'h0003);
      repeat (5) step();
      enable = 1'b0; repeat (3) step();
      enable = 1'b1; repeat (10) step();

      tag = "clamp"; enable = 1'b0;
      do_load(16'h9F7C);

      tag = "add_sat";
      do_load(16'h9930); do_add();
      tag = "add_carry";
      do_load(16'h0910); do_add();
      tag = "add_zero";
      do_load(16'h0000); do_add();
      enable = 1'b1; repeat (5) step();

      tag = "add_tick";
      do_load(16'h0010); step(); do_add(); repeat (2) step();

      tag = "clear_load";
      do_load(16'h0030); repeat (10) step();
      clear = 1'b1; load = 1'b1; data = 16'h0045;
      step();
      clear = 1'b0; load = 1'b0;
      repeat (3) step();

      tag = "random";
      for (int n = 0; n < 400; n++) begin
         clear   = ($urandom_range(0, 99) < 2);
         load    = ($urandom_range(0, 99) < 5);
         add_min = ($urandom_range(0, 99) < 5);
         enable  = ($urandom_range(0, 99) < 85);
         data    = 16'($urandom);
         if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
         step();
      end
      clear = 1'b0; load = 1'b0; add_min = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
